serial_lane_arbiter: RTL
========================

Name: serial_lane_arbiter

Overview:
- Shares one serial-to-parallel deserializer datapath between n_lanes serial requesters.
- Grants one lane at a time using round-robin arbitration, with the grant locked for up to `burst` words.
- Assembles `width`-bit words LSB-first and outputs each word tagged with its source lane id.
- Sits between the serial front-end lanes and the single parallel word consumer.

Parameters:
- n_lanes, 4, number of serial requesters (2..16).
- width, 8, bits per parallel word (>= 2).
- burst, 2, maximum words a lane may send per grant (>= 1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- lane_req  input  n_lanes  per-lane request; held high while the lane has bits to send.
- lane_valid  input  n_lanes  per-lane serial bit valid.
- lane_data  input  n_lanes  per-lane serial bit.
- lane_grant  output  n_lanes  registered one-hot grant; all zero when idle.
- parallel_valid  output  1  one-cycle word strobe.
- parallel_data  output  width  assembled word; first received bit is in bit 0.
- parallel_lane  output  $clog2(n_lanes) (min 1)  id of the lane that produced the word.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, lane_grant=0, bit counter=0, word counter=0, shift register=0.
  - RR pointer=n_lanes-1, so lane 0 has highest priority first.
  - parallel_valid=0.
- IDLE state:
  - If any lane_req is set, pick the first requesting lane searching from pointer+1 upward, with wrap.
  - Register sel, assert lane_grant[sel] next cycle, go to BUSY.
  - No requests: stay in IDLE.
- BUSY state, accept rule:
  - A bit is accepted only when lane_grant[sel] && lane_valid[sel].
  - lane_valid/lane_data of non-granted lanes are ignored entirely.
- BUSY state, word completion (combinational, same cycle as the last bit):
  - On the width-th accepted bit: parallel_valid=1, parallel_data={lane_data[sel], shift[width-2:0]}, parallel_lane=sel.
  - Zero extra latency; parallel_valid depends combinationally on lane_valid[sel].
  - Bit counter returns to 0; word counter increments.
- BUSY state, grant release (evaluated at word completion):
  - If word counter reaches burst, or lane_req[sel] is low in that cycle: release.
  - Release sets pointer=sel and re-arbitrates in the same cycle using that cycle's lane_req.
  - Re-arbitration includes sel itself, at lowest priority.
  - New grant is visible next cycle; no idle bubble if any request is present.
  - If no lane is requesting, lane_grant goes to 0 next cycle and state goes to IDLE.
  - Otherwise the grant is held and the next word proceeds.
- Abort:
  - In BUSY, lane_req[sel]=0 without a completing bit discards the partial word: no parallel_valid, counters cleared.
  - Pointer=sel, then re-arbitrate as above.
  - A bit with lane_valid[sel]=1 in the same cycle as lane_req[sel]=0 is dropped unless it completes the word.
- Grant timing: lane_grant is purely registered; it deasserts the cycle after the releasing event.
- Bit counter width is $clog2(width); word counter width is $clog2(burst+1).
- Async reset mid-word discards all partial state immediately; outputs go to their reset values.

Test Plan:
- Single lane word: lane1 req, bits 1,0,1,0,0,1,0,1 on consecutive cycles after grant -> lane_grant=4'b0010, one strobe with parallel_data=8'hA5, parallel_lane=1, coinciding with the 8th bit.
- Burst limit: lane0 holds req and sends 3 words 8'h11, 8'h22, 8'h33 -> 11 and 22 output with lane 0; grant drops after the 2nd word; lane0 regranted (only requester) the next cycle; 33 output with lane 0.
- Round-robin fairness: lanes 0, 2, 3 all requesting continuously, each sending 8'hFF words, burst=1 -> grant order 0, 2, 3, 0, 2 with no idle cycles between words.
- Ignore non-granted: lane1 granted sends 8'h3C while lane2 toggles valid/data each cycle -> output 8'h3C lane 1 only; lane2 bits never affect parallel_data.
- Abort: lane3 sends 5 bits, then drops req; lane0 requesting -> no parallel_valid; lane0 granted the next cycle; lane0's next word 8'h5A output intact.
- Reset mid-word: rst=0 after 4 accepted bits -> lane_grant=0 and parallel_valid=0 immediately; after release, lane0 priority first; a fresh word 8'hC3 decodes correctly.

Source files
------------

// File: rtl/serial_lane_arbiter.sv
// serial_lane_arbiter: round-robin share of one serial-to-parallel deserializer among n_lanes requesters
module serial_lane_arbiter #(
  parameter int n_lanes = 4,
  parameter int width = 8,
  parameter int burst = 2,
  localparam int lw = (n_lanes > 2) ? $clog2(n_lanes) : 1,
  localparam int bw = $clog2(width),
  localparam int ww = $clog2(burst + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [n_lanes-1:0] lane_req,
  input  logic [n_lanes-1:0] lane_valid,
  input  logic [n_lanes-1:0] lane_data,
  output logic [n_lanes-1:0] lane_grant,
  output logic               parallel_valid,
  output logic [width-1:0]   parallel_data,
  output logic [lw-1:0]      parallel_lane
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state;
  logic [lw-1:0]     sel, ptr, base, pick;
  logic [bw-1:0]     bit_cnt;
  logic [ww-1:0]     word_cnt;
  logic [width-2:0]  shift;
  logic [n_lanes-1:0] one;
  logic              found, acc, done, rearb, any_req;
  int                idx;
  assign any_req = |lane_req;
  assign acc = (state == BUSY) && lane_grant[sel] && lane_valid[sel];
  assign done = acc && (bit_cnt == bw'(width - 1));
  assign rearb = (state == BUSY) && (done ? (word_cnt == ww'(burst - 1) || !lane_req[sel]) : !lane_req[sel]);
  assign parallel_valid = done;
  assign parallel_data = {lane_data[sel], shift};
  assign parallel_lane = sel;
  assign one = n_lanes'(1) << pick;
  // Round-robin search from base+1 upward with wrap; base itself is tried last
  always_comb begin
    base = (state == BUSY) ? sel : ptr;
    found = 1'b0;
    pick = '0;
    idx = 0;
    for (int i = 1; i <= n_lanes; i++) begin
      idx = (int'(base) + i >= n_lanes) ? int'(base) + i - n_lanes : int'(base) + i;
      if (!found && lane_req[lw'(idx)]) begin
        found = 1'b1;
        pick = lw'(idx);
      end
    end
  end
  // Grant FSM, bit/word counters and partial-word storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lane_grant <= '0;
      sel <= '0;
      ptr <= lw'(n_lanes - 1);
      bit_cnt <= '0;
      word_cnt <= '0;
      shift <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        sel <= pick;
        lane_grant <= one;
        state <= BUSY;
      end
    end else if (rearb) begin
      ptr <= sel;
      sel <= pick;
      bit_cnt <= '0;
      word_cnt <= '0;
      lane_grant <= any_req ? one : '0;
      state <= any_req ? BUSY : IDLE;
    end else if (done) begin
      bit_cnt <= '0;
      word_cnt <= word_cnt + 1'b1;
    end else if (acc) begin
      shift[bit_cnt] <= lane_data[sel];
      bit_cnt <= bit_cnt + 1'b1;
    end
  end
endmodule
